// File: rtl/shape_processor_mc_pkg.sv
// Shared types, reset value and legality helpers for the multi-channel shape processor CTRL block.
package shape_processor_mc_pkg;

    typedef enum logic [2:0] {
        SHAPE_CIRCLE    = 3'b000,
        SHAPE_RECTANGLE = 3'b001,
        SHAPE_TRIANGLE  = 3'b010,
        SHAPE_SQUARE    = 3'b011,
        SHAPE_KEEP      = 3'b111
    } shape_e;

    typedef enum logic [2:0] {
        OP_PERIMETER      = 3'b000,
        OP_AREA           = 3'b001,
        OP_IS_SQUARE      = 3'b010,
        OP_IS_EQUILATERAL = 3'b011,
        OP_IS_ISOSCELES   = 3'b100
    } operation_e;

    typedef struct packed {
        shape_e     shape;
        operation_e operation;
    } ctrl_sfr_reg;

    localparam ctrl_sfr_reg CTRL_RESET = '{shape: SHAPE_CIRCLE, operation: OP_PERIMETER};

    function automatic logic is_legal_shape(input logic [2:0] shape);
        return (shape <= 3'b011) || (shape == SHAPE_KEEP);
    endfunction

    function automatic logic is_legal_operation(input logic [2:0] operation);
        return operation <= 3'b100;
    endfunction

    // Shape here is already resolved, so KEEP never reaches this check.
    function automatic logic is_legal_combination(input shape_e shape, input logic [2:0] operation);
        case (operation)
            OP_PERIMETER, OP_AREA:              return 1'b1;
            OP_IS_SQUARE:                       return (shape == SHAPE_RECTANGLE) || (shape == SHAPE_SQUARE);
            OP_IS_EQUILATERAL, OP_IS_ISOSCELES: return shape == SHAPE_TRIANGLE;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shape_processor_mc_ctrl_channel.sv
// One CTRL channel: KEEP_SHAPE resolution, legality check and active (plus optional shadow) register.
// SHAPE_PROC_MC_SHADOW_EN adds a shadow register loaded by writes and copied to active on commit.
module shape_processor_ctrl_channel
    import shape_processor_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_shape,
    input  logic [2:0]  wr_operation,
    input  logic        commit,
    output ctrl_sfr_reg active,
    output ctrl_sfr_reg readback,
    output logic        accept,
    output logic        reject
);

    shape_e      resolved_shape;
    logic        legal;
    ctrl_sfr_reg next_value;

    assign resolved_shape = (wr_shape == SHAPE_KEEP) ? readback.shape : shape_e'(wr_shape);
    assign legal          = is_legal_shape(wr_shape) && is_legal_operation(wr_operation)
                            && is_legal_combination(resolved_shape, wr_operation);
    assign accept         = wr_en && legal;
    assign reject         = wr_en && !legal;
    assign next_value     = '{shape: resolved_shape, operation: operation_e'(wr_operation)};

`ifdef SHAPE_PROC_MC_SHADOW_EN
    ctrl_sfr_reg shadow;

    assign readback = shadow;

    // Commit copies the pre-write shadow; a same-cycle write lands in the shadow only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= CTRL_RESET;
            active <= CTRL_RESET;
        end else begin
            if (accept) shadow <= next_value;
            if (commit) active <= shadow;
        end
    end
`else
    logic unused_commit;

    assign unused_commit = commit;
    assign readback      = active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         active <= CTRL_RESET;
        else if (accept) active <= next_value;
    end
`endif

endmodule

// File: rtl/shape_processor_mc.sv
// Multi-channel shape processor CTRL SFR block: address decode, sticky ERR_STATUS, registered reads.
// SHAPE_PROC_MC_SHADOW_EN enables shadowed CTRL registers and the COMMIT address.
module shape_processor_mc
    import shape_processor_mc_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [31:0]               write_data,
    input  logic                      read,
    output logic [31:0]               read_data,
    output logic                      read_valid,
    output logic                      error,
    output logic [NUM_CHANNELS*3-1:0] ctrl_shape,
    output logic [NUM_CHANNELS*3-1:0] ctrl_operation,
    output logic [NUM_CHANNELS-1:0]   ctrl_changed
);

    localparam logic [ADDR_W-1:0] ERR_ADDR    = ADDR_W'(NUM_CHANNELS);
    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(NUM_CHANNELS + 1);

    logic [NUM_CHANNELS-1:0] ctrl_wr, commit, accept, reject, err_clr, changed_next;
    logic [NUM_CHANNELS-1:0] err_status;
    ctrl_sfr_reg             active   [NUM_CHANNELS];
    ctrl_sfr_reg             readback [NUM_CHANNELS];
    logic                    addr_ctrl, addr_err, addr_commit, unmapped;
    logic [31:0]             read_mux;
    logic                    unused_write_data;

    assign unused_write_data = ^write_data;
    assign addr_ctrl         = addr < ADDR_W'(NUM_CHANNELS);
    assign addr_err          = addr == ERR_ADDR;
`ifdef SHAPE_PROC_MC_SHADOW_EN
    assign addr_commit       = addr == COMMIT_ADDR;
    assign changed_next      = commit;
`else
    assign addr_commit       = 1'b0;
    assign changed_next      = accept;
`endif
    assign unmapped          = !(addr_ctrl || addr_err || addr_commit);
    assign err_clr           = (write && addr_err) ? write_data[NUM_CHANNELS-1:0] : '0;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign ctrl_wr[c] = write && (addr == ADDR_W'(c));
        assign commit[c]  = write && addr_commit && write_data[c];

        shape_processor_ctrl_channel u_channel (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (ctrl_wr[c]),
            .wr_shape     (write_data[10:8]),
            .wr_operation (write_data[2:0]),
            .commit       (commit[c]),
            .active       (active[c]),
            .readback     (readback[c]),
            .accept       (accept[c]),
            .reject       (reject[c])
        );

        assign ctrl_shape[3*c +: 3]     = active[c].shape;
        assign ctrl_operation[3*c +: 3] = active[c].operation;
    end

    always_comb begin
        read_mux = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (addr == ADDR_W'(c)) begin
                read_mux[10:8] = readback[c].shape;
                read_mux[2:0]  = readback[c].operation;
            end
        end
        if (addr_err) read_mux = 32'(err_status);
    end

    // A same-cycle set outranks the write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_status   <= '0;
            error        <= 1'b0;
            ctrl_changed <= '0;
            read_data    <= '0;
            read_valid   <= 1'b0;
        end else begin
            err_status   <= (err_status & ~err_clr) | reject;
            error        <= (|reject) || (write && unmapped);
            ctrl_changed <= changed_next;
            read_valid   <= read;
            if (read) read_data <= read_mux;
        end
    end

endmodule

// File: tb/tb_shape_processor_mc.sv
// Scoreboard bench for shape_processor_mc: expected read data queued at issue, compared on read_valid.
module tb_shape_processor_mc;

    localparam int NCH = 4;
    localparam int AW  = 5;
`ifdef SHAPE_PROC_MC_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            write = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [31:0]     write_data = '0;
    logic            read = 1'b0;
    logic [31:0]     read_data;
    logic            read_valid;
    logic            error;
    logic [NCH*3-1:0] ctrl_shape;
    logic [NCH*3-1:0] ctrl_operation;
    logic [NCH-1:0]  ctrl_changed;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_exp [$];
    string       sb_tag [$];
    logic [31:0] exp_word;
    string       exp_name;

    shape_processor_mc #(.NUM_CHANNELS(NCH), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .write          (write),
        .addr           (addr),
        .write_data     (write_data),
        .read           (read),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .error          (error),
        .ctrl_shape     (ctrl_shape),
        .ctrl_operation (ctrl_operation),
        .ctrl_changed   (ctrl_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (read_valid) begin
            if (sb_exp.size() == 0) begin
                check("sb_underflow", 32'(sb_exp.size()), 32'd1);
            end else begin
                exp_word = sb_exp.pop_front();
                exp_name = sb_tag.pop_front();
                check(exp_name, read_data, exp_word);
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        write = 1'b1; addr = a; write_data = d;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        read = 1'b1; addr = a;
        sb_exp.push_back(exp); sb_tag.push_back(tag);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic rw(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
        read = 1'b1; write = 1'b1; addr = a; write_data = d;
        sb_exp.push_back(exp); sb_tag.push_back(tag);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_read_valid", 32'(read_valid), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_changed", 32'(ctrl_changed), 32'h0);
        check("rst_shape", 32'(ctrl_shape), 32'h0);
        check("rst_operation", 32'(ctrl_operation), 32'h0);
        @(negedge clk) rst = 1'b0;
        idle(1);

        for (int c = 0; c < NCH; c++) rd(AW'(c), 32'h0, "rst_ctrl_read");
        rd(AW'(NCH), 32'h0, "rst_err_read");

        // illegal combination on a triangle
        wr(5'd2, 32'h0202);
        check("illegal_combo_error", 32'(error), 32'h1);
        check("illegal_combo_changed", 32'(ctrl_changed), 32'h0);
        idle(1);
        check("error_one_cycle", 32'(error), 32'h0);
        rd(AW'(NCH), 32'h4, "err_status_bit2");
        rd(5'd2, 32'h0, "ctrl2_unchanged");
        wr(AW'(NCH), 32'h4);
        check("err_clear_no_error", 32'(error), 32'h0);
        rd(AW'(NCH), 32'h0, "err_status_cleared");

        // square then keep-shape with IS_SQUARE
        wr(5'd1, 32'h0300);
        check("sq_changed", 32'(ctrl_changed), SHADOW ? 32'h0 : 32'h2);
        check("sq_error", 32'(error), 32'h0);
        wr(5'd1, 32'h0702);
        check("keep_changed", 32'(ctrl_changed), SHADOW ? 32'h0 : 32'h2);
        check("keep_shape", 32'(ctrl_shape[5:3]), SHADOW ? 32'h0 : 32'h3);
        check("keep_operation", 32'(ctrl_operation[5:3]), SHADOW ? 32'h0 : 32'h2);
        rd(5'd1, 32'h0302, "keep_readback");
`ifdef SHAPE_PROC_MC_SHADOW_EN
        wr(AW'(NCH + 1), 32'h2);
        check("commit1_changed", 32'(ctrl_changed), 32'h2);
        check("commit1_shape", 32'(ctrl_shape[5:3]), 32'h3);
        check("commit1_operation", 32'(ctrl_operation[5:3]), 32'h2);
`endif

        // keep-shape on a circle with a triangle-only operation
        wr(5'd0, 32'h0703);
        check("keep_circle_error", 32'(error), 32'h1);
        wr(AW'(NCH), 32'h0);
        rd(AW'(NCH), 32'h1, "err_zero_write_keeps");
        wr(AW'(NCH), 32'h1);
        rd(AW'(NCH), 32'h0, "err_bit0_cleared");

        // unmapped address and COMMIT address
        wr(5'd31, 32'hFFFF_FFFF);
        check("unmapped_error", 32'(error), 32'h1);
        check("unmapped_changed", 32'(ctrl_changed), 32'h0);
        rd(AW'(NCH), 32'h0, "unmapped_no_err_status");
        rd(5'd31, 32'h0, "unmapped_read");
        wr(AW'(NCH + 1), 32'h0);
        check("commit_addr_error", 32'(error), SHADOW ? 32'h0 : 32'h1);
        rd(AW'(NCH + 1), 32'h0, "commit_read");

        // assorted legal and illegal words
        wr(5'd3, 32'h0204);
        check("tri_iso_error", 32'(error), 32'h0);
        wr(5'd0, 32'h0401);
        check("bad_shape_error", 32'(error), 32'h1);
        wr(5'd0, 32'h0005);
        check("bad_op_error", 32'(error), 32'h1);
        wr(5'd3, 32'h0102);
        check("rect_issq_error", 32'(error), 32'h0);
        rd(5'd3, 32'h0102, "ctrl3_readback");
        wr(5'd0, 32'hFFFF_F8F9);
        check("ignored_bits_error", 32'(error), 32'h0);
        rd(5'd0, 32'h0001, "ignored_bits_readback");
        rd(AW'(NCH), 32'h1, "err_after_mix");

        // same-cycle read and write returns pre-write value
        rw(5'd2, 32'h0300, 32'h0, "rw_prewrite");
        rd(5'd2, 32'h0300, "rw_postwrite");

`ifdef SHAPE_PROC_MC_SHADOW_EN
        wr(5'd3, 32'h0101);
        rd(5'd3, 32'h0101, "shadow_readback");
        check("shadow_active_shape", 32'(ctrl_shape[11:9]), 32'h0);
        wr(AW'(NCH + 1), 32'h18);
        check("commit3_changed", 32'(ctrl_changed), 32'h8);
        check("commit3_shape", 32'(ctrl_shape[11:9]), 32'h1);
        check("commit3_operation", 32'(ctrl_operation[11:9]), 32'h1);
`endif

        // reset in the middle of a read and write
        idle(2);
        read = 1'b1; write = 1'b1; addr = 5'd1; write_data = 32'h0001;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        check("midrst_read_valid", 32'(read_valid), 32'h0);
        check("midrst_shape", 32'(ctrl_shape), 32'h0);
        check("midrst_changed", 32'(ctrl_changed), 32'h0);
        check("midrst_error", 32'(error), 32'h0);
        @(negedge clk) rst = 1'b0;
        idle(1);
        rd(5'd1, 32'h0, "midrst_ctrl1");
        rd(AW'(NCH), 32'h0, "midrst_err");

        idle(3);
        check("sb_drain", 32'(sb_exp.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
